// File: rtl/xoodyak_msg_feeder.sv
// xoodyak_msg_feeder
//   Front end of the XOODYAK hash core. Takes one hash command (length plus a
//   byte stream), buffers the full message, pulses core_start, then streams the
//   buffered bytes to the core under core_busy back-pressure. Once the core has
//   emitted HASH_BYTES digest bytes (core_valid cycles), done pulses and the
//   block returns to IDLE. One job in flight at a time.
//
// Ports
//   clk, resetn              clock / synchronous active-low reset
//   cmd_valid/len/ready/err  command channel; err pulses for len > MAX_LEN
//   in_valid/data/ready      message byte channel, accepted only in LOAD
//   core_start               one-cycle start pulse to the core
//   core_msg                 registered message byte presented to the core
//   core_msg_len             length of the current/last accepted job
//   core_busy                core cannot consume core_msg this cycle
//   core_valid               core emits one digest byte this cycle
//   done                     one-cycle pulse after the last digest byte
//   active                   high whenever the FSM is not IDLE
module xoodyak_msg_feeder #(
   parameter int MAX_LEN    = 1024,
   parameter int LEN_W      = 12,
   parameter int HASH_BYTES = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_ready,
   output logic             cmd_err,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             core_start,
   output logic [7:0]       core_msg,
   output logic [LEN_W-1:0] core_msg_len,
   input  logic             core_busy,
   input  logic             core_valid,
   output logic             done,
   output logic             active
);

   localparam int               ADDR_W    = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] HASH_LAST = LEN_W'(HASH_BYTES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, STREAM, HASH} state_t;

   state_t           state;
   logic [7:0]       msg_buf [MAX_LEN];
   logic [LEN_W-1:0] wr_idx;
   logic [LEN_W-1:0] rd_idx;
   logic [LEN_W-1:0] rd_nxt;
   logic [LEN_W-1:0] hash_cnt;
   logic [LEN_W-1:0] last_idx;
   logic             wr_en;
   logic             wr_last;

   // in_ready is registered and high exactly while in LOAD
   assign wr_en    = (state == LOAD) && in_valid && in_ready;
   assign last_idx = core_msg_len - LEN_W'(1);
   assign wr_last  = wr_en && (wr_idx == last_idx);
   assign rd_nxt   = rd_idx + LEN_W'(1);

   // Message buffer; contents are not reset
   always_ff @(posedge clk) begin
      if (wr_en)
         msg_buf[wr_idx[ADDR_W-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         cmd_ready    <= 1'b1;
         cmd_err      <= 1'b0;
         in_ready     <= 1'b0;
         core_start   <= 1'b0;
         core_msg     <= '0;
         core_msg_len <= '0;
         done         <= 1'b0;
         active       <= 1'b0;
         wr_idx       <= '0;
         rd_idx       <= '0;
         hash_cnt     <= '0;
      end else begin
         cmd_err    <= 1'b0;
         core_start <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_len > MAX_LEN_L) begin
                     cmd_err <= 1'b1;
                  end else begin
                     core_msg_len <= cmd_len;
                     cmd_ready    <= 1'b0;
                     active       <= 1'b1;
                     wr_idx       <= '0;
                     rd_idx       <= '0;
                     if (cmd_len == '0) begin
                        state      <= START;
                        core_start <= 1'b1;
                        core_msg   <= '0;
                     end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               if (wr_en) begin
                  wr_idx <= wr_idx + LEN_W'(1);
                  if (wr_last) begin
                     state      <= START;
                     in_ready   <= 1'b0;
                     core_start <= 1'b1;
                     // Prefetch byte 0; for a 1-byte job it is being written
                     // on this very edge, so bypass the buffer.
                     core_msg   <= (wr_idx == '0) ? in_data : msg_buf[0];
                  end
               end
            end
            START: begin
               // core_msg already holds byte 0 and stays there for STREAM
               rd_idx   <= '0;
               hash_cnt <= '0;
               state    <= (core_msg_len == '0) ? HASH : STREAM;
            end
            STREAM: begin
               if (!core_busy) begin
                  if (rd_idx == last_idx) begin
                     state <= HASH;
                  end else begin
                     // Read one ahead so the next byte is ready next cycle
                     rd_idx   <= rd_nxt;
                     core_msg <= msg_buf[rd_nxt[ADDR_W-1:0]];
                  end
               end
            end
            HASH: begin
               if (core_valid) begin
                  hash_cnt <= hash_cnt + LEN_W'(1);
                  if (hash_cnt == HASH_LAST) begin
                     done      <= 1'b1;
                     state     <= IDLE;
                     active    <= 1'b0;
                     cmd_ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xoodyak_msg_feeder.sv
// Testbench for xoodyak_msg_feeder. Messages are held as byte queues; the
// expected core stream is simply the message in order, one byte per unstalled
// cycle, and done follows the HASH_BYTES-th digest byte.
module tb_xoodyak_msg_feeder;

   localparam int MAX_LEN    = 1024;
   localparam int LEN_W      = 12;
   localparam int HASH_BYTES = 32;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             cmd_ready;
   logic             cmd_err;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = '0;
   logic             in_ready;
   logic             core_start;
   logic [7:0]       core_msg;
   logic [LEN_W-1:0] core_msg_len;
   logic             core_busy = 1'b0;
   logic             core_valid = 1'b0;
   logic             done;
   logic             active;

   int checks = 0;
   int errors = 0;

   xoodyak_msg_feeder #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .HASH_BYTES(HASH_BYTES)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .core_start(core_start), .core_msg(core_msg), .core_msg_len(core_msg_len),
      .core_busy(core_busy), .core_valid(core_valid),
      .done(done), .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one whole job and checks it against the message queue.
   // mode 0: byte i = i%256, mode 1: random bytes. stall_idx/stall_cyc force
   // core_busy at one byte; abort_at pulls reset when that byte is showing.
   task automatic run_job(input int len, input int mode, input int gap_pct,
                          input int busy_pct, input int stall_idx, input int stall_cyc,
                          input int abort_at, output int load_cyc,
                          output int stream_cyc, output int stall_seen);
      byte unsigned msg[$];
      byte unsigned exp0;
      int k;
      int cyc;
      int stall_left;
      bit v;
      bit b;
      load_cyc = 0;
      stream_cyc = 0;
      stall_seen = 0;
      msg = {};
      for (int i = 0; i < len; i++)
         msg.push_back(mode == 0 ? 8'(i % 256) : 8'($urandom));

      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL idle_cmd_ready got %0b want 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (core_msg_len !== LEN_W'(len) || active !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_accept len %0d active %0b ready %0b want len %0d active 1 ready 0",
                  core_msg_len, active, cmd_ready, len);
      end

      // LOAD
      k = 0;
      while (k < len && load_cyc < 20 * len + 100) begin
         checks++;
         if (in_ready !== 1'b1 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL load_state byte %0d in_ready %0b start %0b want 1 0", k, in_ready, core_start);
         end
         v = ($urandom_range(99) >= gap_pct);
         in_valid   = v;
         in_data    = v ? msg[k] : 8'($urandom);
         core_valid = 1'($urandom_range(1));
         tick();
         load_cyc++;
         if (v) k++;
      end
      in_valid   = 1'b0;
      core_valid = 1'b0;
      if (k < len) begin
         errors++; $display("FAIL load_timeout accepted %0d want %0d", k, len);
         return;
      end

      // START cycle
      exp0 = (len > 0) ? msg[0] : 8'h00;
      checks++;
      if (core_start !== 1'b1 || core_msg !== exp0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_cycle start %0b msg %02h in_ready %0b want 1 %02h 0",
                  core_start, core_msg, in_ready, exp0);
      end
      core_busy  = 1'($urandom_range(1));
      core_valid = 1'($urandom_range(1));
      tick();
      core_busy  = 1'b0;

      // STREAM
      k = 0;
      stall_left = stall_cyc;
      while (k < len && stream_cyc < 20 * len + 100) begin
         if (k == abort_at) begin
            resetn     = 1'b0;
            core_valid = 1'b0;
            tick();
            resetn = 1'b1;
            return;
         end
         checks++;
         if (core_msg !== msg[k] || core_start !== 1'b0) begin
            errors++;
            $display("FAIL stream_byte %0d got %02h start %0b want %02h start 0",
                     k, core_msg, core_start, msg[k]);
         end
         if (k == stall_idx) stall_seen++;
         if (k == stall_idx && stall_left > 0) begin
            b = 1'b1;
            stall_left--;
         end else begin
            b = ($urandom_range(99) < busy_pct);
         end
         core_busy  = b;
         core_valid = 1'($urandom_range(1));
         tick();
         stream_cyc++;
         if (!b) k++;
      end
      core_busy  = 1'b0;
      core_valid = 1'b0;
      if (k < len) begin
         errors++; $display("FAIL stream_timeout consumed %0d want %0d", k, len);
         return;
      end

      // HASH
      k = 0;
      cyc = 0;
      while (k < HASH_BYTES && cyc < 1000) begin
         checks++;
         if (done !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL hash_wait digest %0d done %0b active %0b want 0 1", k, done, active);
         end
         v = 1'($urandom_range(1));
         core_valid = v;
         tick();
         cyc++;
         if (v) k++;
      end
      core_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || active !== 1'b0 || cmd_ready !== 1'b1 || core_msg_len !== LEN_W'(len)) begin
         errors++;
         $display("FAIL job_done done %0b active %0b ready %0b len %0d want 1 0 1 %0d",
                  done, active, cmd_ready, core_msg_len, len);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width got %0b want 0", done);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || cmd_err !== 1'b0 || in_ready !== 1'b0 || core_start !== 1'b0 ||
          done !== 1'b0 || active !== 1'b0 || core_msg !== 8'h00 || core_msg_len !== '0) begin
         errors++;
         $display("FAIL reset_state ready %0b err %0b in_rdy %0b start %0b done %0b act %0b msg %02h len %0d want 1 0 0 0 0 0 00 0",
                  cmd_ready, cmd_err, in_ready, core_start, done, active, core_msg, core_msg_len);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_len0();
      int lc, sc, ss;
      run_job(0, 0, 0, 0, -1, 0, -1, lc, sc, ss);
      checks++;
      if (lc !== 0) begin
         errors++; $display("FAIL len0_load_cycles got %0d want 0", lc);
      end
   endtask

   task automatic test_stream_nostall();
      int lc, sc, ss;
      run_job(19, 0, 0, 0, -1, 0, -1, lc, sc, ss);
      checks++;
      if (lc !== 19 || sc !== 19) begin
         errors++; $display("FAIL nostall_cycles load %0d stream %0d want 19 19", lc, sc);
      end
   endtask

   task automatic test_stall();
      int lc, sc, ss;
      run_job(19, 0, 0, 0, 5, 3, -1, lc, sc, ss);
      checks++;
      if (ss !== 4 || sc !== 22) begin
         errors++; $display("FAIL stall_hold held %0d stream %0d want 4 22", ss, sc);
      end
   endtask

   task automatic test_full_len();
      int lc, sc, ss;
      run_job(MAX_LEN, 0, 40, 25, -1, 0, -1, lc, sc, ss);
   endtask

   task automatic test_bad_len();
      int lc, sc, ss;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(MAX_LEN + 1);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (cmd_err !== 1'b1 || cmd_ready !== 1'b1 || active !== 1'b0) begin
         errors++;
         $display("FAIL bad_len_err err %0b ready %0b active %0b want 1 1 0", cmd_err, cmd_ready, active);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (in_ready !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL bad_len_idle in_ready %0b active %0b want 0 0", in_ready, active);
         end
         tick();
         checks++;
         if (cmd_err !== 1'b0) begin
            errors++; $display("FAIL bad_len_pulse cmd_err %0b want 0", cmd_err);
         end
      end
      in_valid = 1'b0;
      run_job(1, 1, 0, 0, -1, 0, -1, lc, sc, ss);
   endtask

   task automatic test_reset_mid();
      int lc, sc, ss;
      run_job(19, 0, 0, 0, -1, 0, 7, lc, sc, ss);
      checks++;
      if (cmd_ready !== 1'b1 || active !== 1'b0 || in_ready !== 1'b0 || core_start !== 1'b0 ||
          done !== 1'b0 || cmd_err !== 1'b0 || core_msg !== 8'h00 || core_msg_len !== '0) begin
         errors++;
         $display("FAIL midjob_reset ready %0b act %0b in_rdy %0b start %0b done %0b err %0b msg %02h len %0d want 1 0 0 0 0 0 00 0",
                  cmd_ready, active, in_ready, core_start, done, cmd_err, core_msg, core_msg_len);
      end
      run_job(3, 1, 0, 0, -1, 0, -1, lc, sc, ss);
   endtask

   task automatic test_random_jobs();
      int lc, sc, ss;
      for (int j = 0; j < 6; j++)
         run_job(int'($urandom_range(40)), 1, 30, 30, -1, 0, -1, lc, sc, ss);
   endtask

   initial begin
      test_reset();
      test_len0();
      test_stream_nostall();
      test_stall();
      test_full_len();
      test_bad_len();
      test_reset_mid();
      test_random_jobs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
